mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, maximum REQ+WAIT cycles before a bus-timeout abort.
REQ-002 SHALL have clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have valid_in  input  1 / pc_in  input  32 / instruction_in  input  32 / alu_res_in  input  32 (effective address or ALU result) / reg_2_in  input  32 (store data), driven by the EX/ME register.
REQ-005 SHALL have stall_out  output  1  holds the EX/ME register while high.
REQ-006 SHALL have dmem_req  output  1 / dmem_we  output  1 / dmem_addr  output  32 (word-aligned) / dmem_be  output  4 / dmem_wdata  output  32.
REQ-007 SHALL have dmem_gnt  input  1  request accepted / dmem_rvalid  input  1  read data valid / dmem_rdata  input  32.
REQ-008 SHALL have valid_out  output  1 / pc_out  output  32 / instruction_out  output  32 / alu_res_out  output  32 / mem_res_out  output  32 (extended load data) / bus_err_out  output  1 / misalign_out  output  1, all registered, feeding the ME/WB stage.

Function
REQ-009 SHALL decode load as opcode 0000011 and store as 0100011; width from funct3 [14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL implement FSM IDLE, REQ, WAIT; dmem_req=1 only in REQ; dmem_we=1 in REQ for stores.
REQ-011 In IDLE with valid non-memory op: register pc/instruction/alu_res, valid_out=1, mem_res_out=0, stall_out=0; latency 1 cycle.
REQ-012 In IDLE with valid load/store: latch address, data and funct3 internally, stall_out=1, next state REQ, valid_out=0 next cycle.
REQ-013 REQ, store, dmem_gnt=1: stall_out=0, valid_out=1 next edge, next state IDLE (2-cycle minimum latency).
REQ-014 REQ, load, dmem_gnt=1: next state WAIT, stall_out=1; dmem_rvalid in REQ is ignored.
REQ-015 WAIT, dmem_rvalid=1: stall_out=0, mem_res_out=extended data and valid_out=1 next edge, next state IDLE (3-cycle minimum load latency).
REQ-016 stall_out SHALL be combinational and low in every completing cycle so upstream advances on the same edge outputs register.
REQ-017 dmem_addr={addr[31:2],2'b00}; dmem_be: B 0001<<addr[1:0], H 0011<<{addr[1],0}, W 1111.
REQ-018 dmem_wdata: B {4{reg_2[7:0]}}, H {2{reg_2[15:0]}}, W reg_2.
REQ-019 Load data SHALL be rdata shifted right by 8*addr[1:0], then sign-extended (B,H) or zero-extended (BU,HU).
REQ-020 Timeout counter SHALL clear on entering REQ, increment per non-completing REQ/WAIT cycle; when it equals MAX_WAIT: abort, stall_out=0, valid_out=1, bus_err_out=1, mem_res_out=0, next IDLE.
REQ-021 Completion SHALL take priority over timeout in the same cycle.
REQ-022 valid_in=0 in IDLE: valid_out=0, bus_err_out=0, no request.

Reset
REQ-023 Reset SHALL force IDLE, counter 0, dmem_req=0, and every registered output to 0 immediately, including mid-access; an in-flight access is dropped.
REQ-024 Response signals arriving after reset SHALL be ignored in IDLE.

Configuration
REQ-025 Macro MEM_STAGE_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 SHALL issue no request, complete in IDLE in 1 cycle with valid_out=1, misalign_out=1, mem_res_out=0, stall_out=0.
REQ-026 Macro undefined: misalign_out tied 0; misaligned accesses proceed with offending low address bits ignored (H uses addr[1], W ignores addr[1:0]).

Verification
REQ-027 SB addr 0x103, reg_2 0x000000AB, gnt in REQ -> dmem_be 1000, wdata 0xABABABAB, valid_out 2 cycles after presentation, stall high 1 cycle.
REQ-028 LB addr 0x102, rdata 0x00800000, gnt immediate, rvalid next cycle -> mem_res_out 0xFFFFFF80; LBU same -> 0x00000080; 3-cycle latency.
REQ-029 LW, gnt never asserted, MAX_WAIT=15 -> abort after 15 counted cycles, bus_err_out=1, stall_out falls.
REQ-030 ADD back-to-back with LW, rvalid delayed 4 cycles -> ADD output 1 cycle, LW held, stall_out high until rvalid cycle.
REQ-031 Reset asserted in WAIT -> dmem_req, valid_out, stall_out 0 immediately; later rvalid produces no output.
REQ-032 With macro, LH addr 0x101 -> misalign_out=1, no dmem_req; without macro -> dmem_be 0011, request issued.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage and the data memory.
//
// Handshake: the master raises dmem_req, together with stable dmem_we,
// dmem_addr, dmem_be and dmem_wdata, in every cycle of the request phase.
// The request is accepted on a rising edge where dmem_gnt is high. For a
// read, the slave later returns the data with dmem_rvalid high for one cycle,
// and dmem_rdata is qualified by that pulse. A read response that arrives
// before the grant, or while no access is in flight, is ignored. Writes get
// no response phase.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_gnt,
    input  dmem_rvalid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_gnt,
    output dmem_rvalid,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage (EX/ME -> ME/WB).
// Non-memory ops pass through with one cycle of latency. Loads and stores
// run a three-state bus FSM (IDLE -> REQ -> WAIT). A bus-timeout counter
// aborts an access after MAX_WAIT REQ/WAIT cycles with bus_err_out set.
// Optional feature: define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses in IDLE instead of issuing them with the offending
// low address bits ignored.
module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  // EX/ME register
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] reg_2_in,
  output logic        stall_out,
  // data-memory bus
  mem_stage_if.master dmem,
  // ME/WB register
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_res_out,
  output logic        bus_err_out,
  output logic        misalign_out,
  // FSM state for observation
  output logic [1:0]  dbg_state_o
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  // Counter only ever holds 0 .. MAX_WAIT-1; reaching MAX_WAIT aborts.
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Access size is funct3[1:0]: 00 byte, 01 halfword, otherwise word.
  // funct3[2] selects zero-extension for loads.

  // Byte lane where the access starts; ignored low bits are dropped here.
  function automatic logic [1:0] lane_off(input logic [1:0] size,
                                          input logic [1:0] lo);
    case (size)
      2'b00:   lane_off = lo;
      2'b01:   lane_off = {lo[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] off);
    case (size)
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Store data is replicated across lanes so byte enables pick the right one.
  function automatic logic [31:0] store_data(input logic [1:0]  size,
                                             input logic [31:0] d);
    case (size)
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0]  size,
                                           input logic        uns,
                                           input logic [31:0] rdata,
                                           input logic [1:0]  off);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (size)
      2'b00:   load_ext = uns ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = uns ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] lo);
    misaligned = (size == 2'b01 && lo[0]) || (size[1] && lo != 2'b00);
  endfunction

  // FSM and counter
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // access captured when a load/store is accepted in IDLE
  logic [31:0] addr_q, data_q, pc_q, instr_q;
  logic [2:0]  f3_q;
  logic        store_q;

  // ME/WB register
  logic        valid_q, valid_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mem_out_q, mem_out_d;
  logic        bus_err_q, bus_err_d;
  logic        misalign_q, misalign_d;

  // combinational control
  logic        stall_c;
  logic        accept_c;
  logic        done_c;

  // decode of the op waiting in the EX/ME register
  logic [6:0]  in_opc;
  logic        in_load, in_store, in_mem, in_trap;

  assign in_opc   = instruction_in[6:0];
  assign in_load  = (in_opc == OPC_LOAD);
  assign in_store = (in_opc == OPC_STORE);
  assign in_mem   = in_load || in_store;
  assign in_trap  = TRAP_EN && in_mem &&
                    misaligned(instruction_in[13:12], alu_res_in[1:0]);

  // Next-state, counter and ME/WB register inputs; defaults first.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_c     = 1'b0;
    accept_c    = 1'b0;
    done_c      = 1'b0;
    valid_d     = 1'b0;
    bus_err_d   = 1'b0;
    misalign_d  = 1'b0;
    pc_out_d    = pc_out_q;
    instr_out_d = instr_out_q;
    alu_out_d   = alu_out_q;
    mem_out_d   = mem_out_q;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (in_mem && !in_trap) begin
            // start a bus access; upstream holds until it completes
            accept_c = 1'b1;
            stall_c  = 1'b1;
            state_d  = S_REQ;
            cnt_d    = '0;
          end else begin
            // pass-through (or trapped misaligned access) in one cycle
            valid_d     = 1'b1;
            misalign_d  = in_trap;
            pc_out_d    = pc_in;
            instr_out_d = instruction_in;
            alu_out_d   = alu_res_in;
            mem_out_d   = '0;
          end
        end
      end

      S_REQ, S_WAIT: begin
        // A store finishes on its grant, a load on its read data. A load
        // grant only moves to WAIT and still counts toward the timeout.
        done_c = (state_q == S_REQ) ? (dmem.dmem_gnt && store_q)
                                    : dmem.dmem_rvalid;
        if (done_c || cnt_q == CNT_LAST) begin
          // completion wins over timeout in the same cycle
          state_d     = S_IDLE;
          valid_d     = 1'b1;
          bus_err_d   = !done_c;
          pc_out_d    = pc_q;
          instr_out_d = instr_q;
          alu_out_d   = addr_q;
          mem_out_d   = (done_c && !store_q)
                        ? load_ext(f3_q[1:0], f3_q[2], dmem.dmem_rdata,
                                   lane_off(f3_q[1:0], addr_q[1:0]))
                        : '0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (state_q == S_REQ && dmem.dmem_gnt) state_d = S_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and timeout counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the accepted access so the EX/ME register may change afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
    end else if (accept_c) begin
      addr_q  <= alu_res_in;
      data_q  <= reg_2_in;
      pc_q    <= pc_in;
      instr_q <= instruction_in;
      f3_q    <= instruction_in[14:12];
      store_q <= in_store;
    end
  end

  // ME/WB output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_out_q    <= '0;
      instr_out_q <= '0;
      alu_out_q   <= '0;
      mem_out_q   <= '0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_out_q    <= pc_out_d;
      instr_out_q <= instr_out_d;
      alu_out_q   <= alu_out_d;
      mem_out_q   <= mem_out_d;
      bus_err_q   <= bus_err_d;
      misalign_q  <= misalign_d;
    end
  end

  // Reset also masks the combinational handshake outputs right away.
  assign stall_out = stall_c && !reset;

  assign dmem.dmem_req   = (state_q == S_REQ) && !reset;
  assign dmem.dmem_we    = (state_q == S_REQ) && store_q;
  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_be    = byte_en(f3_q[1:0], lane_off(f3_q[1:0], addr_q[1:0]));
  assign dmem.dmem_wdata = store_data(f3_q[1:0], data_q);

  assign valid_out       = valid_q;
  assign pc_out          = pc_out_q;
  assign instruction_out = instr_out_q;
  assign alu_res_out     = alu_out_q;
  assign mem_res_out     = mem_out_q;
  assign bus_err_out     = bus_err_q;
  assign misalign_out    = misalign_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed corner cases plus randomized op streams
// with a randomized memory responder, checked against a timeline model.
module tb_mem_stage;
  localparam int MAX_WAIT = 15;
  localparam int RW = 130;  // {bus_err, misalign, pc, instr, alu_res, mem_res}

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ADD   = 7'b0110011;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        valid_in;
  logic [31:0] pc_in, instruction_in, alu_res_in, reg_2_in;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] pc_out, instruction_out, alu_res_out, mem_res_out;
  logic        bus_err_out, misalign_out;
  logic [1:0]  dbg_state_o;

  mem_stage_if bus();

  mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock           (clock),
    .reset           (reset),
    .valid_in        (valid_in),
    .pc_in           (pc_in),
    .instruction_in  (instruction_in),
    .alu_res_in      (alu_res_in),
    .reg_2_in        (reg_2_in),
    .stall_out       (stall_out),
    .dmem            (bus),
    .valid_out       (valid_out),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .alu_res_out     (alu_res_out),
    .mem_res_out     (mem_res_out),
    .bus_err_out     (bus_err_out),
    .misalign_out    (misalign_out),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [RW-1:0] exp_q[$];
  bit out_pending = 1'b0;

  logic [6:0] nm_opc [4] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111};

  task automatic check(input string tag, input logic [RW-1:0] got,
                       input logic [RW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_off(input logic [2:0] f3, input logic [31:0] addr);
    case (f3[1:0])
      2'd0:    return int'(addr[1:0]);
      2'd1:    return addr[1] ? 2 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] b;
    case (f3[1:0])
      2'd0:    b = 4'b0001;
      2'd1:    b = 4'b0011;
      default: b = 4'b1111;
    endcase
    return b << ref_off(f3, addr);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'd1:    return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] lane;
    lane = rdata >> (8 * ref_off(f3, addr));
    case (f3)
      3'd0:    return {{24{lane[7]}}, lane[7:0]};
      3'd1:    return {{16{lane[15]}}, lane[15:0]};
      3'd4:    return {24'd0, lane[7:0]};
      3'd5:    return {16'd0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  function automatic bit ref_misalign(input logic [2:0] f3, input logic [31:0] addr);
    return TRAP_EN && ((f3[1:0] == 2'd1 && addr[0]) ||
                       (f3[1:0] == 2'd2 && addr[1:0] != 2'd0));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic sample_out(input string ctx);
    check({ctx, "_valid_out"}, valid_out, out_pending);
    if (out_pending) begin
      if (exp_q.size() == 0) begin
        check({ctx, "_exp_q_empty"}, 1, 0);
      end else begin
        check({ctx, "_result"},
              {bus_err_out, misalign_out, pc_out, instruction_out, alu_res_out, mem_res_out},
              exp_q.pop_front());
      end
      out_pending = 1'b0;
    end
  endtask

  // One idle cycle; optionally throws a stray bus response at the stage.
  task automatic idle_cycle(input bit force_rsp);
    @(posedge clock); #1;
    valid_in        = 1'b0;
    instruction_in  = $urandom;
    bus.dmem_gnt    = force_rsp ? 1'b1 : 1'($urandom_range(0, 1));
    bus.dmem_rvalid = force_rsp ? 1'b1 : 1'($urandom_range(0, 1));
    bus.dmem_rdata  = $urandom;
    @(negedge clock);
    sample_out("idle");
    check("idle_stall", stall_out, 0);
    check("idle_req", bus.dmem_req, 0);
  endtask

  // Presents one op and plays the memory: grant g cycles into REQ, read data
  // r cycles after the grant cycle's successor. Expectations come from the
  // access timeline: an access needs done_n bus cycles and is cut at MAX_WAIT.
  task automatic run_op(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] rdata, input int g, input int r);
    bit is_load, is_store, is_mem, trap, abort_op;
    logic [2:0] f3;
    int done_n, end_n, req_last;
    is_load  = (instr[6:0] == OPC_LOAD);
    is_store = (instr[6:0] == OPC_STORE);
    is_mem   = is_load || is_store;
    f3       = instr[14:12];
    trap     = is_mem && ref_misalign(f3, addr);
    abort_op = 1'b0;
    end_n    = 0;
    req_last = 0;
    if (is_mem && !trap) begin
      done_n = is_store ? g + 1 : g + 2 + r;
      if (done_n <= MAX_WAIT) end_n = done_n;
      else begin
        end_n    = MAX_WAIT;
        abort_op = 1'b1;
      end
      req_last = (g + 1 < end_n) ? g + 1 : end_n;
    end

    for (int n = 0; n <= end_n; n++) begin
      @(posedge clock); #1;
      if (n == 0) begin
        valid_in       = 1'b1;
        pc_in          = pc;
        instruction_in = instr;
        alu_res_in     = addr;
        reg_2_in       = reg2;
      end
      if (n >= 1 && n <= g + 1) bus.dmem_gnt = (n == g + 1);
      else                      bus.dmem_gnt = 1'($urandom_range(0, 1));
      bus.dmem_rdata = $urandom;
      if (is_load && n == g + 2 + r) begin
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = rdata;
      end else if (is_load && n >= g + 2) begin
        bus.dmem_rvalid = 1'b0;
      end else begin
        bus.dmem_rvalid = 1'($urandom_range(0, 1));
      end

      @(negedge clock);
      sample_out("op");
      check("stall", stall_out, n < end_n);
      check("req", bus.dmem_req, n >= 1 && n <= req_last);
      if (n == 1 && req_last >= 1) begin
        check("we", bus.dmem_we, is_store);
        check("addr", bus.dmem_addr, {addr[31:2], 2'b00});
        check("be", bus.dmem_be, ref_be(f3, addr));
        if (is_store) check("wdata", bus.dmem_wdata, ref_wdata(f3, reg2));
      end
      if (n == end_n) begin
        exp_q.push_back({abort_op, trap, pc, instr, addr,
                         (is_load && !trap && !abort_op) ? ref_load(f3, addr, rdata) : 32'd0});
        out_pending = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] ins;
    ins        = $urandom;
    ins[14:12] = f3;
    ins[6:0]   = opc;
    return ins;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int kind, g, r;
    logic [2:0] f3;
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    reset = 1'b1;
    valid_in = 1'b0; pc_in = '0; instruction_in = '0; alu_res_in = '0; reg_2_in = '0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_outs", {bus_err_out, misalign_out, pc_out, instruction_out, alu_res_out, mem_res_out}, 0);
    check("rst_req", bus.dmem_req, 0);
    check("rst_stall", stall_out, 0);
    check("rst_state", dbg_state_o, 0);
    reset = 1'b0;
    idle_cycle(1'b1);

    // SB 0x103, LB/LBU 0x102, LW timeout, ADD then slow LW, LH 0x101
    run_op(mk_instr(OPC_STORE, 3'd0), 32'h100, 32'h103, 32'h000000AB, 0, 0, 0);
    run_op(mk_instr(OPC_LOAD, 3'd0), 32'h104, 32'h102, 0, 32'h00800000, 0, 0);
    run_op(mk_instr(OPC_LOAD, 3'd4), 32'h108, 32'h102, 0, 32'h00800000, 0, 0);
    run_op(mk_instr(OPC_LOAD, 3'd2), 32'h10C, 32'h200, 0, 32'h12345678, 99, 0);
    run_op(mk_instr(OPC_ADD, 3'd0), 32'h110, 32'h55, 0, 0, 0, 0);
    run_op(mk_instr(OPC_LOAD, 3'd2), 32'h114, 32'h300, 0, 32'hCAFEF00D, 0, 3);
    run_op(mk_instr(OPC_LOAD, 3'd1), 32'h118, 32'h101, 0, 32'h00ABCD00, 0, 0);
    // timeout boundary: finishing exactly on the last cycle vs one later
    run_op(mk_instr(OPC_STORE, 3'd2), 32'h11C, 32'h400, 32'hDEADBEEF, 0, 14, 0);
    run_op(mk_instr(OPC_LOAD, 3'd2), 32'h120, 32'h404, 0, 32'h0BADF00D, 0, 13);
    run_op(mk_instr(OPC_LOAD, 3'd2), 32'h124, 32'h408, 0, 32'h0BADF00D, 0, 14);
    run_op(mk_instr(OPC_STORE, 3'd1), 32'h128, 32'h40A, 32'h0000BEEF, 0, 15, 0);
    idle_cycle(1'b1);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      g = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(12, 16);
      r = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(10, 14);
      if (kind < 3) begin
        run_op(mk_instr(nm_opc[$urandom_range(0, 3)], 3'($urandom)), $urandom, $urandom,
               $urandom, $urandom, g, r);
      end else if (kind < 7) begin
        f3 = ld_f3[$urandom_range(0, 4)];
        run_op(mk_instr(OPC_LOAD, f3), $urandom, $urandom, $urandom, $urandom, g, r);
      end else if (kind < 9) begin
        f3 = 3'($urandom_range(0, 2));
        run_op(mk_instr(OPC_STORE, f3), $urandom, $urandom, $urandom, $urandom, g, r);
      end else begin
        idle_cycle(1'b0);
      end
    end
    idle_cycle(1'b0);

    // reset while a load waits for its data; the late data must be dropped
    @(posedge clock); #1;
    valid_in = 1'b1; instruction_in = mk_instr(OPC_LOAD, 3'd2); alu_res_in = 32'h40;
    pc_in = 32'h500; bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
    @(posedge clock); #1;
    bus.dmem_gnt = 1'b1;
    @(posedge clock); #1;
    bus.dmem_gnt = 1'b0;
    @(negedge clock);
    check("wait_stall", stall_out, 1);
    check("wait_req", bus.dmem_req, 0);
    #1 reset = 1'b1;
    #1;
    check("rstw_req", bus.dmem_req, 0);
    check("rstw_stall", stall_out, 0);
    check("rstw_valid", valid_out, 0);
    check("rstw_state", dbg_state_o, 0);
    valid_in = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    out_pending = 1'b0;
    exp_q.delete();
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
